capture_ctrl: RTL and testbench

CAPTURE_CTRL -- requirements
Module: capture_ctrl

---
 rtl/capture_pkg.sv | 14 +
 rtl/capture_ctrl.sv | 108 ++++++++++
 tb/tb_capture_ctrl.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/capture_pkg.sv
// Shared definitions for the capture controller and the RAM read-back / UART dump logic.
package capture_pkg;

  localparam int unsigned ADDR_W_DEF = 9;

  typedef enum logic [2:0] {
    IDLE,
    PRETRIG,
    ARMED,
    POSTTRIG,
    DONE
  } capState_t;

endpackage

// File: rtl/capture_ctrl.sv
// Circular-buffer capture sequencer: fills pre-trigger history, arms, waits for a
// trigger, then records trig_pos post-trigger samples before flagging completion.
module capture_ctrl
  import capture_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              done_clr,
  input  logic              smpl_en,
  input  logic              trig_in,
  input  logic [ADDR_W-1:0] trig_pos,
  output logic              armed,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [ADDR_W-1:0] trig_addr,
  output logic              triggered,
  output logic              capture_done
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  capState_t         state;
  logic [ADDR_W:0]   cnt;
  logic [ADDR_W:0]   cntInc;
  logic [ADDR_W-1:0] effPos;
  logic [ADDR_W-1:0] effPosIn;
  logic [ADDR_W:0]   preTarget;

  assign we        = smpl_en && (state == PRETRIG || state == ARMED || state == POSTTRIG);
  assign cntInc    = cnt + (ADDR_W+1)'(1);
  assign effPosIn  = (trig_pos == '0) ? ADDR_W'(1) : trig_pos;
  assign preTarget = (ADDR_W+1)'(DEPTH) - {1'b0, effPos};

  // One counter serves both phases: pre-trigger history, then post-trigger samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      effPos       <= ADDR_W'(1);
      waddr        <= '0;
      trig_addr    <= '0;
      armed        <= 1'b0;
      triggered    <= 1'b0;
      capture_done <= 1'b0;
    end else begin
      if (we) waddr <= waddr + ADDR_W'(1);

      if (done_clr) begin
        state        <= IDLE;
        armed        <= 1'b0;
        triggered    <= 1'b0;
        capture_done <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (run) begin
              state     <= PRETRIG;
              waddr     <= '0;
              cnt       <= '0;
              triggered <= 1'b0;
              effPos    <= effPosIn;
            end
          end
          PRETRIG: begin
            if (we) begin
              cnt <= cntInc;
              if (cntInc == preTarget) begin
                state <= ARMED;
                armed <= 1'b1;
              end
            end
          end
          ARMED: begin
            if (trig_in) begin
              trig_addr <= waddr;
              triggered <= 1'b1;
              armed     <= 1'b0;
              cnt       <= smpl_en ? (ADDR_W+1)'(1) : '0;
              // The trigger-cycle write is post sample 1, which may already finish a depth-1 capture.
              if (smpl_en && effPos == ADDR_W'(1)) begin
                state        <= DONE;
                capture_done <= 1'b1;
              end else begin
                state <= POSTTRIG;
              end
            end
          end
          POSTTRIG: begin
            if (we) begin
              cnt <= cntInc;
              if (cntInc == {1'b0, effPos}) begin
                state        <= DONE;
                capture_done <= 1'b1;
              end
            end
          end
          DONE: begin
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_capture_ctrl.sv
// Self-checking bench for capture_ctrl: directed scenarios plus randomized captures
// checked against a write-counting model of the capture window.
module tb_capture_ctrl;
  import capture_pkg::*;

  localparam int unsigned AW    = 9;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk;
  logic          rst_n;
  logic          run;
  logic          done_clr;
  logic          smpl_en;
  logic          trig_in;
  logic [AW-1:0] trig_pos;
  logic          armed;
  logic          we;
  logic [AW-1:0] waddr;
  logic [AW-1:0] trig_addr;
  logic          triggered;
  logic          capture_done;

  int          checks = 0;
  int          errors = 0;
  int unsigned cycCnt = 0;

  capture_ctrl #(.ADDR_W(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .done_clr    (done_clr),
    .smpl_en     (smpl_en),
    .trig_in     (trig_in),
    .trig_pos    (trig_pos),
    .armed       (armed),
    .we          (we),
    .waddr       (waddr),
    .trig_addr   (trig_addr),
    .triggered   (triggered),
    .capture_done(capture_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cycCnt <= cycCnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    checks++;
    errors++;
    $error("FAIL %s timeout", tag);
  endtask

  // mode 0: strobe every cycle, 1: random, n>=2: every n-th cycle
  task automatic getS(input int mode, output logic s);
    if (mode == 0)      s = 1'b1;
    else if (mode == 1) s = 1'($urandom_range(0, 1));
    else                s = ((cycCnt % mode) == 0);
  endtask

  task automatic drive(input logic s, input logic t, input logic c, input logic r);
    smpl_en  = s;
    trig_in  = t;
    done_clr = c;
    run      = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkWe(input string tag, input logic exp);
    @(negedge clk);
    chk(tag, 32'(we), 32'(exp));
  endtask

  task automatic capture(input int tp, input int mode, input int armCycles, input bit trigNoise,
                         input int abortAt, input bit resetArmed, input bit runWithClr);
    int   eff, pre, writes, armW, post, guard, expTA;
    logic s, t;
    eff = (tp == 0) ? 1 : tp;
    pre = DEPTH - eff;
    trig_pos = AW'(tp);
    drive(0, 0, 0, 1);
    checkWe("we_idle_run", 1'b0);
    tick();
    drive(0, 0, 0, 0);
    chk("armed_start", 32'(armed), 0);
    chk("trig_start", 32'(triggered), 0);
    chk("waddr_start", 32'(waddr), 0);

    writes = 0;
    guard  = 0;
    while (writes < pre) begin
      getS(mode, s);
      t = trigNoise ? 1'b1 : 1'($urandom_range(0, 1));
      drive(s, t, 0, 0);
      checkWe("we_pre", s);
      tick();
      if (s) writes++;
      chk("armed_pre", 32'(armed), 32'(writes == pre));
      chk("trig_pre", 32'(triggered), 0);
      guard++;
      if (guard > 20000) begin
        timeout("pretrig");
        return;
      end
    end
    chk("waddr_armed", 32'(waddr), 32'(pre % DEPTH));

    if (resetArmed) begin
      drive(1, 0, 0, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_armed", 32'(armed), 0);
      chk("rst_we", 32'(we), 0);
      chk("rst_waddr", 32'(waddr), 0);
      chk("rst_trig_addr", 32'(trig_addr), 0);
      chk("rst_triggered", 32'(triggered), 0);
      chk("rst_done", 32'(capture_done), 0);
      @(negedge clk);
      rst_n = 1'b1;
      checkWe("we_after_rst", 1'b0);
      tick();
      chk("waddr_after_rst", 32'(waddr), 0);
      drive(0, 0, 0, 0);
      return;
    end

    armW = 0;
    for (int i = 0; i < armCycles; i++) begin
      getS(mode, s);
      drive(s, 0, 0, 0);
      checkWe("we_armed", s);
      tick();
      if (s) armW++;
      chk("armed_hold", 32'(armed), 1);
      chk("trig_armed", 32'(triggered), 0);
    end
    expTA = (pre + armW) % DEPTH;

    getS(mode, s);
    drive(s, 1, 0, 0);
    checkWe("we_trig", s);
    tick();
    drive(0, 0, 0, 0);
    chk("triggered", 32'(triggered), 1);
    chk("armed_fall", 32'(armed), 0);
    chk("trig_addr", 32'(trig_addr), 32'(expTA));
    post = s ? 1 : 0;
    chk("done_trig", 32'(capture_done), 32'(post == eff));

    guard = 0;
    while (post < eff) begin
      if (abortAt >= 0 && post == abortAt) begin
        drive(1, 0, 1, 0);
        checkWe("we_abort", 1'b1);
        tick();
        chk("abort_triggered", 32'(triggered), 0);
        chk("abort_done", 32'(capture_done), 0);
        chk("abort_armed", 32'(armed), 0);
        drive(1, 0, 0, 0);
        checkWe("we_after_abort", 1'b0);
        tick();
        drive(0, 0, 0, 0);
        return;
      end
      getS(mode, s);
      t = 1'($urandom_range(0, 1));
      drive(s, t, 0, 0);
      checkWe("we_post", s);
      tick();
      if (s) post++;
      chk("done_post", 32'(capture_done), 32'(post == eff));
      chk("trig_addr_hold", 32'(trig_addr), 32'(expTA));
      guard++;
      if (guard > 20000) begin
        timeout("posttrig");
        return;
      end
    end

    chk("waddr_oldest", 32'(waddr), 32'((expTA + eff) % DEPTH));
    chk("triggered_done", 32'(triggered), 1);
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 0, 1);
      checkWe("we_done", 1'b0);
      tick();
      chk("done_hold", 32'(capture_done), 1);
      chk("waddr_hold", 32'(waddr), 32'((expTA + eff) % DEPTH));
    end
    drive(1, 0, 1, runWithClr);
    checkWe("we_clr", 1'b0);
    tick();
    chk("clr_done", 32'(capture_done), 0);
    chk("clr_triggered", 32'(triggered), 0);
    drive(1, 0, 0, 0);
    checkWe("we_idle", 1'b0);
    tick();
    drive(0, 0, 0, 0);
  endtask

  initial begin
    rst_n    = 1'b0;
    trig_pos = '0;
    drive(1, 1, 1, 1);
    #3;
    chk("reset_armed", 32'(armed), 0);
    chk("reset_we", 32'(we), 0);
    chk("reset_waddr", 32'(waddr), 0);
    chk("reset_trig_addr", 32'(trig_addr), 0);
    chk("reset_triggered", 32'(triggered), 0);
    chk("reset_done", 32'(capture_done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0, 0);
    tick();

    capture(256, 0, 44, 0, -1, 0, 0);  // trigger at address 300, ends at 44
    chk("dir_trig_addr_300", 32'(trig_addr), 300);
    capture(100, 0, 0, 1, -1, 0, 0);   // trigger held through pre-trigger
    chk("dir_trig_addr_412", 32'(trig_addr), 412);
    capture(8, 4, 3, 0, -1, 0, 0);
    capture(8, 0, 0, 0, 3, 0, 0);      // abort during post-trigger
    capture(5, 1, 2, 0, -1, 0, 1);     // run together with done_clr in DONE
    capture(0, 0, 5, 0, -1, 0, 0);
    capture(0, 1, 3, 0, -1, 0, 0);
    capture(20, 1, 0, 0, -1, 1, 0);    // reset while armed

    for (int n = 0; n < 6; n++) begin
      capture(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 40)), 1'($urandom_range(0, 1)), -1, 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
